// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: datapath-wide scalar types.
// word_t is the 32-bit machine word.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/pc_predict_pkg.sv
// pc_predict_pkg: counter type, counter states and saturating helper.
// Shared by pc_predict_unit and btb_array (macro PC_PREDICT_STATS_EN).
package pc_predict_pkg;
   typedef logic [1:0] ctr_t;

   localparam ctr_t SNT = 2'b00;
   localparam ctr_t WNT = 2'b01;
   localparam ctr_t WT  = 2'b10;
   localparam ctr_t ST  = 2'b11;

   // Saturating +/-1 on the low w bits (w from 1 to 32).
   function automatic logic [31:0] sat_step(
      input logic [31:0] v,
      input logic        up,
      input int unsigned w
   );
      logic [31:0] top;
      top = (w >= 32) ? 32'hFFFF_FFFF
                      : ((32'd1 << w) - 32'd1);
      if (up)
         sat_step = (v >= top) ? top : v + 32'd1;
      else
         sat_step = (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction
endpackage

// File: rtl/pc_predict_unit_if.sv
// pc_predict_unit_if: fetch/resolve bundle of the PC predictor.
// Stat signals exist only with PC_PREDICT_STATS_EN.
interface pc_predict_unit_if #(
   parameter int WIDTH = 32
);
   logic             ihit;
   logic             stall;
   logic [WIDTH-1:0] pcaddr;
   logic [WIDTH-1:0] nxt_pc;
   logic             pred_taken;
   logic [WIDTH-1:0] pred_target;
   logic             res_valid;
   logic             res_is_branch;
   logic [WIDTH-1:0] res_pc;
   logic             res_taken;
   logic [WIDTH-1:0] res_target;
   logic             res_pred_taken;
   logic [WIDTH-1:0] res_pred_target;
   logic             flush;
`ifdef PC_PREDICT_STATS_EN
   logic [31:0]      stat_branches;
   logic [31:0]      stat_mispredicts;
`endif

   modport master (
      output ihit, stall,
      output res_valid, res_is_branch, res_pc,
      output res_taken, res_target,
      output res_pred_taken, res_pred_target,
`ifdef PC_PREDICT_STATS_EN
      input  stat_branches, stat_mispredicts,
`endif
      input  pcaddr, nxt_pc, pred_taken,
      input  pred_target, flush
   );

   modport slave (
      input  ihit, stall,
      input  res_valid, res_is_branch, res_pc,
      input  res_taken, res_target,
      input  res_pred_taken, res_pred_target,
`ifdef PC_PREDICT_STATS_EN
      output stat_branches, stat_mispredicts,
`endif
      output pcaddr, nxt_pc, pred_taken,
      output pred_target, flush
   );
endinterface

// File: rtl/btb_array.sv
// btb_array: direct-mapped BTB storage, one comb read port and one
// registered update port applying the 2-bit counter policy.
module btb_array
   import pc_predict_pkg::*;
#(
   parameter int  WIDTH   = 32,
   parameter int  ENTRIES = 16,
   localparam int IDX     = $clog2(ENTRIES),
   localparam int TW      = WIDTH - IDX - 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [IDX-1:0]   rd_idx_i,
   output logic             rd_valid_o,
   output logic [TW-1:0]    rd_tag_o,
   output logic [WIDTH-3:0] rd_tgt_o,
   output ctr_t             rd_ctr_o,
   input  logic             wr_en_i,
   input  logic [IDX-1:0]   wr_idx_i,
   input  logic [TW-1:0]    wr_tag_i,
   input  logic             wr_taken_i,
   input  logic [WIDTH-3:0] wr_tgt_i
);
   logic [ENTRIES-1:0] valid_q;
   logic [TW-1:0]      tag_q [ENTRIES];
   logic [WIDTH-3:0]   tgt_q [ENTRIES];
   ctr_t               ctr_q [ENTRIES];

   ctr_t        cur;
   ctr_t        ctr_nxt;
   logic        wr_hit;
   logic        at_rail;
   logic [31:0] step;

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_tgt_o   = tgt_q[rd_idx_i];
   assign rd_ctr_o   = ctr_q[rd_idx_i];

   always_comb begin
      cur     = ctr_q[wr_idx_i];
      wr_hit  = valid_q[wr_idx_i]
             && (tag_q[wr_idx_i] == wr_tag_i);
      step    = sat_step({30'b0, cur}, wr_taken_i, 2);
      at_rail = (cur == (wr_taken_i ? ST : SNT));
      ctr_nxt = at_rail ? cur : ctr_t'(step);
   end

   // A not-taken miss never allocates; a taken miss evicts the alias.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i] <= '0;
            tgt_q[i] <= '0;
            ctr_q[i] <= WNT;
         end
      end else if (wr_en_i) begin
         if (wr_hit) begin
            ctr_q[wr_idx_i] <= ctr_nxt;
            if (wr_taken_i)
               tgt_q[wr_idx_i] <= wr_tgt_i;
         end else if (wr_taken_i) begin
            valid_q[wr_idx_i] <= 1'b1;
            tag_q[wr_idx_i]   <= wr_tag_i;
            tgt_q[wr_idx_i]   <= wr_tgt_i;
            ctr_q[wr_idx_i]   <= WT;
         end
      end
   end
endmodule

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC with BTB prediction and EX redirect/flush.
// PC_PREDICT_STATS_EN adds saturating branch/mispredict counters.
module pc_predict_unit
   import pc_predict_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               BTB_ENTRIES = 16,
   parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
   input logic               CLK,
   input logic               nRST,
   pc_predict_unit_if.slave  io
);
   localparam int IDX = $clog2(BTB_ENTRIES);
   localparam int TW  = WIDTH - IDX - 2;

   logic [WIDTH-1:0] pcaddr_q;
   logic [WIDTH-1:0] pcaddr_d;
   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] pred_target;
   logic [WIDTH-1:0] redir_pc;
   logic             rd_valid;
   logic [TW-1:0]    rd_tag;
   logic [WIDTH-3:0] rd_tgt;
   ctr_t             rd_ctr;
   logic             hit;
   logic             pred_taken;
   logic             res_br;
   logic             mispredict;

   btb_array #(
      .WIDTH   (WIDTH),
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk_i      (CLK),
      .rst_ni     (nRST),
      .rd_idx_i   (pcaddr_q[IDX+1:2]),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_tgt_o   (rd_tgt),
      .rd_ctr_o   (rd_ctr),
      .wr_en_i    (res_br),
      .wr_idx_i   (io.res_pc[IDX+1:2]),
      .wr_tag_i   (io.res_pc[WIDTH-1:IDX+2]),
      .wr_taken_i (io.res_taken),
      .wr_tgt_i   (io.res_target[WIDTH-1:2])
   );

   assign hit = rd_valid
             && (rd_tag == pcaddr_q[WIDTH-1:IDX+2]);
   assign pred_taken = hit && (rd_ctr inside {WT, ST});
   assign seq_pc = pcaddr_q + WIDTH'(4);
   assign pred_target = pred_taken ? {rd_tgt, 2'b00}
                                   : seq_pc;

   assign res_br = io.res_valid && io.res_is_branch;
   assign mispredict = res_br
      && ((io.res_taken != io.res_pred_taken)
       || (io.res_taken
        && (io.res_target != io.res_pred_target)));

   // Redirect keeps the target's low bits; only the BTB drops them.
   assign redir_pc = io.res_taken ? io.res_target
                                  : io.res_pc + WIDTH'(4);

   always_comb begin
      pcaddr_d = pcaddr_q;
      if (mispredict)
         pcaddr_d = redir_pc;
      else if (io.stall)
         pcaddr_d = pcaddr_q;
      else if (io.ihit)
         pcaddr_d = pred_target;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         pcaddr_q <= RESET_PC;
      else
         pcaddr_q <= pcaddr_d;
   end

   assign io.pcaddr      = pcaddr_q;
   assign io.nxt_pc      = seq_pc;
   assign io.pred_taken  = pred_taken;
   assign io.pred_target = pred_target;
   assign io.flush       = mispredict;

`ifdef PC_PREDICT_STATS_EN
   import cpu_types_pkg::*;

   word_t stat_br_q;
   word_t stat_mp_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         if (res_br)
            stat_br_q <= sat_step(stat_br_q, 1'b1, 32);
         if (mispredict)
            stat_mp_q <= sat_step(stat_mp_q, 1'b1, 32);
      end
   end

   assign io.stat_branches    = stat_br_q;
   assign io.stat_mispredicts = stat_mp_q;
`endif
endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed vectors feeding an expectation queue,
// drained and compared by a negedge monitor.
module tb_pc_predict_unit;
   import cpu_types_pkg::*;

   typedef struct {
      string name;
      logic  st;
      word_t pc;
      logic  pt;
      word_t tgt;
      logic  fl;
      word_t sb;
      word_t sm;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   exp_t q[$];
   exp_t e;
   int   total = 0;
   int   bad = 0;

   pc_predict_unit_if #(.WIDTH(32)) io();

   pc_predict_unit #(
      .WIDTH       (32),
      .BTB_ENTRIES (16),
      .RESET_PC    (32'h100)
   ) dut (
      .CLK  (clk),
      .nRST (rst_n),
      .io   (io)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      while (q.size() > 0) begin
         e = q.pop_front();
         total++;
         if (!e.st) begin
            if (io.pcaddr !== e.pc || io.pred_taken !== e.pt
             || io.pred_target !== e.tgt || io.flush !== e.fl
             || io.nxt_pc !== e.pc + 32'd4) begin
               bad++;
               $display("FAIL %s: got pc=%h pt=%0b tgt=%h fl=%0b nxt=%h want pc=%h pt=%0b tgt=%h fl=%0b",
                        e.name, io.pcaddr, io.pred_taken,
                        io.pred_target, io.flush, io.nxt_pc,
                        e.pc, e.pt, e.tgt, e.fl);
            end
         end
`ifdef PC_PREDICT_STATS_EN
         else if (io.stat_branches !== e.sb
               || io.stat_mispredicts !== e.sm) begin
            bad++;
            $display("FAIL %s: got br=%0d mp=%0d want br=%0d mp=%0d",
                     e.name, io.stat_branches,
                     io.stat_mispredicts, e.sb, e.sm);
         end
`endif
      end
   end

   task automatic expect_pc(input word_t p, input logic t,
                            input word_t g, input logic f,
                            input string nm);
      q.push_back('{nm, 1'b0, p, t, g, f, 32'd0, 32'd0});
   endtask

   task automatic cyc(input logic ih, input logic st,
                      input logic rv, input logic rb,
                      input word_t rpc, input logic rt,
                      input word_t rtg, input logic rpt,
                      input word_t rptg, input word_t epc,
                      input logic ept, input word_t etg,
                      input logic efl, input string nm);
      io.ihit = ih;
      io.stall = st;
      io.res_valid = rv;
      io.res_is_branch = rb;
      io.res_pc = rpc;
      io.res_taken = rt;
      io.res_target = rtg;
      io.res_pred_taken = rpt;
      io.res_pred_target = rptg;
      expect_pc(epc, ept, etg, efl, nm);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ih, input logic st,
                       input word_t epc, input logic ept,
                       input word_t etg, input string nm);
      cyc(ih, st, 0, 0, 0, 0, 0, 0, 0, epc, ept, etg, 0, nm);
   endtask

   task automatic rsv(input logic ih, input logic st,
                      input word_t rpc, input logic rt,
                      input word_t rtg, input logic rpt,
                      input word_t rptg, input word_t epc,
                      input logic ept, input word_t etg,
                      input logic efl, input string nm);
      cyc(ih, st, 1, 1, rpc, rt, rtg, rpt, rptg,
          epc, ept, etg, efl, nm);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no end at %0t want finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      io.ihit = 1'b1;
      io.stall = 1'b0;
      io.res_valid = 1'b0;
      io.res_is_branch = 1'b0;
      io.res_pc = '0;
      io.res_taken = 1'b0;
      io.res_target = '0;
      io.res_pred_taken = 1'b0;
      io.res_pred_target = '0;
      repeat (2) @(posedge clk);
      #1;
      expect_pc(32'h100, 0, 32'h104, 0, "reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      idle(1, 0, 32'h100, 0, 32'h104, "seq0");
      idle(1, 0, 32'h104, 0, 32'h108, "seq1");
      rsv(1, 0, 32'h104, 1, 32'h200, 0, 32'h108,
          32'h108, 0, 32'h10C, 1, "beq_mp_taken");
`ifdef PC_PREDICT_STATS_EN
      q.push_back('{"stats", 1'b1, 32'd0, 1'b0, 32'd0, 1'b0,
                    32'd1, 32'd1});
`endif
      rsv(0, 0, 32'h100, 0, 32'h0, 1, 32'h300,
          32'h200, 0, 32'h204, 1, "redir_104");
      idle(1, 0, 32'h104, 1, 32'h200, "btb_hit_wt");
      rsv(0, 0, 32'h104, 0, 32'h0, 1, 32'h200,
          32'h200, 0, 32'h204, 1, "beq_nt1");
      rsv(0, 0, 32'h104, 0, 32'h0, 0, 32'h108,
          32'h108, 0, 32'h10C, 0, "beq_nt2");
      rsv(0, 0, 32'h100, 0, 32'h0, 1, 32'h300,
          32'h108, 0, 32'h10C, 1, "redir_104b");
      idle(0, 0, 32'h104, 0, 32'h108, "ctr_snt");
      idle(1, 1, 32'h104, 0, 32'h108, "stall_hold");
      rsv(1, 1, 32'h104, 1, 32'h300, 0, 32'h108,
          32'h104, 0, 32'h108, 1, "stall_mp");
      rsv(0, 0, 32'h104, 1, 32'h300, 1, 32'h300,
          32'h300, 0, 32'h304, 0, "correct_pred");
      rsv(0, 0, 32'h100, 0, 32'h0, 1, 32'h300,
          32'h300, 0, 32'h304, 1, "redir_104c");
      idle(1, 0, 32'h104, 1, 32'h300, "btb_new_tgt");

      rsv(0, 0, 32'h40, 1, 32'h500, 0, 32'h44,
          32'h300, 0, 32'h304, 1, "alloc_40");
      rsv(0, 0, 32'h3C, 0, 32'h0, 1, 32'h500,
          32'h500, 0, 32'h504, 1, "redir_40");
      rsv(0, 0, 32'h80, 1, 32'h600, 0, 32'h84,
          32'h40, 1, 32'h500, 1, "alias_rbw");
      rsv(0, 0, 32'h3C, 0, 32'h0, 1, 32'h600,
          32'h600, 0, 32'h604, 1, "redir_40b");
      idle(0, 0, 32'h40, 0, 32'h44, "alias_evict");

      rsv(0, 0, 32'hFFFF_FFF8, 1, 32'hFFFF_FFFC, 0,
          32'hFFFF_FFFC, 32'h40, 0, 32'h44, 1, "jump_top");
      idle(1, 0, 32'hFFFF_FFFC, 0, 32'h0, "wrap");
      rsv(0, 0, 32'h8, 1, 32'h702, 0, 32'hC,
          32'h0, 0, 32'h4, 1, "unaligned");
      rsv(0, 0, 32'h4, 0, 32'h0, 1, 32'h8,
          32'h702, 0, 32'h706, 1, "redir_8");
      idle(0, 0, 32'h8, 1, 32'h700, "btb_drop_lsb");
      cyc(0, 0, 1, 0, 32'h8, 1, 32'h900, 0, 32'h0,
          32'h8, 1, 32'h700, 0, "non_branch");

      io.ihit = 1'b1;
      io.res_valid = 1'b1;
      io.res_is_branch = 1'b1;
      io.res_pc = 32'h8;
      io.res_taken = 1'b0;
      io.res_pred_taken = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      io.res_valid = 1'b0;
      expect_pc(32'h100, 0, 32'h104, 0, "async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsv(0, 0, 32'h4, 0, 32'h0, 1, 32'h8,
          32'h100, 0, 32'h104, 1, "post_rst_redir");
      idle(0, 0, 32'h8, 0, 32'hC, "post_rst_miss");

      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
